// File: rtl/seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// seq_mon_pkg
//
// Purpose : shared types and default parameter values for the count sequence
//           monitor (count_seq_monitor) and its step classifier
//           (seq_step_classify).
//
// Contents:
//   state_t        - monitor FSM states: S_IDLE, S_ACQ, S_LOCK
//   step_t         - classification of one observed step:
//                    STEP_UP, STEP_DN, STEP_HOLD, STEP_BAD
//   DEF_WIDTH      - default width of the observed count
//   DEF_LOCK_CNT   - default number of consecutive same-direction steps
//                    needed to lock
//   DEF_ERR_CNT_W  - default width of the saturating error counter
//   RUN_W          - width of the run-length counter (holds LOCK_CNT up to 15)
// -----------------------------------------------------------------------------
package seq_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DN   = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_LOCK_CNT  = 2;
    localparam int DEF_ERR_CNT_W = 8;

    // LOCK_CNT is limited to 1..15, so a 4-bit run counter always suffices.
    localparam int RUN_W = 4;

endpackage : seq_mon_pkg

// File: rtl/seq_step_classify.sv
// -----------------------------------------------------------------------------
// seq_step_classify
//
// Purpose : purely combinational classification of the step between two
//           consecutive count samples. The difference is taken modulo
//           2^WIDTH so that wrap-around steps classify like any other step.
//
//           delta = (cur - prev) mod 2^WIDTH
//             1        -> STEP_UP
//             all-ones -> STEP_DN
//             0        -> STEP_HOLD
//             other    -> STEP_BAD
//
// Parameters:
//   WIDTH - width of the observed count
//
// Ports:
//   prev  in   WIDTH  previously sampled count
//   cur   in   WIDTH  currently sampled count
//   step  out  step_t classification of prev -> cur
// -----------------------------------------------------------------------------
module seq_step_classify
    import seq_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output step_t            step
);

    logic [WIDTH-1:0] delta;

    // Natural truncation to WIDTH bits gives the modulo-2^WIDTH difference.
    assign delta = cur - prev;

    always_comb begin
        step = STEP_BAD;
        // UP is tested first so that a degenerate WIDTH = 1 (where 1 is also
        // all-ones) still classifies as a forward step.
        if (delta == WIDTH'(1)) begin
            step = STEP_UP;
        end else if (delta == {WIDTH{1'b1}}) begin
            step = STEP_DN;
        end else if (delta == '0) begin
            step = STEP_HOLD;
        end
    end

endmodule : seq_step_classify

// File: rtl/count_seq_monitor.sv
// -----------------------------------------------------------------------------
// count_seq_monitor
//
// Purpose : receive-side checker for an up/down counter's count bus. It
//           samples the stream, infers the counting direction, locks once it
//           has seen LOCK_CNT consecutive same-direction steps, and then flags
//           legal wrap-arounds, direction reversals and illegal steps. Illegal
//           steps seen while locked are counted in a saturating error counter.
//
// Configuration macro:
//   SEQ_MON_HOLD_OK_EN - when defined, a repeated value (HOLD step) is legal
//                        in every state: no state change, no err pulse, and
//                        the acquisition run length is kept. When undefined a
//                        HOLD clears the run in S_ACQ and is an error in
//                        S_LOCK.
//
// Parameters:
//   WIDTH      - width of the observed count (default 4)
//   LOCK_CNT   - consecutive same-direction legal steps to lock, 1..15
//   ERR_CNT_W  - width of the saturating error counter
//
// Ports:
//   Clk        in   1          system clock, rising edge
//   reset      in   1          synchronous, active-high reset
//   count_in   in   WIDTH      observed counter value
//   count_vld  in   1          count_in valid; nothing is sampled when low
//   locked     out  1          monitor locked to a direction
//   dir_up     out  1          locked or candidate direction, 1 = up
//   wrap       out  1          one-cycle pulse on a legal wrap while locked
//   dir_chg    out  1          one-cycle pulse when a locked stream reverses
//   err        out  1          one-cycle pulse on an illegal step
//   err_cnt    out  ERR_CNT_W  saturating count of err pulses
//   dbg_state  out  state_t    current FSM state, for observation only
//
// Handshake: count_vld is a qualifier only; the monitor never back-pressures.
// A sample is consumed on every rising edge where count_vld is high, and its
// effect is visible on the registered outputs right after that edge. While
// count_vld is low all history holds and every pulse output drops to 0.
// -----------------------------------------------------------------------------
module count_seq_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_vld,
    output logic                 locked,
    output logic                 dir_up,
    output logic                 wrap,
    output logic                 dir_chg,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output state_t               dbg_state
);

`ifdef SEQ_MON_HOLD_OK_EN
    localparam bit HOLD_OK = 1'b1;
`else
    localparam bit HOLD_OK = 1'b0;
`endif

    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t                state_q;
    logic [WIDTH-1:0]      prev_q;
    logic [RUN_W-1:0]      run_q;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t                state_d;
    logic [WIDTH-1:0]      prev_d;
    logic [RUN_W-1:0]      run_d;
    logic                  locked_d;
    logic                  dir_up_d;
    logic                  wrap_d;
    logic                  dir_chg_d;
    logic                  err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_d;

    // -------------------------------------------------------------------------
    // Step classification of prev -> count_in
    // -------------------------------------------------------------------------
    step_t step;

    seq_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev (prev_q),
        .cur  (count_in),
        .step (step)
    );

    logic             is_move;     // UP or DN
    logic             step_up;     // direction of a move, 1 = up
    logic             same_dir;    // move agrees with dir_up
    logic             is_hold_ok;  // HOLD that is treated as legal
    logic [RUN_W-1:0] run_inc;     // run + 1, saturating
    logic [RUN_W-1:0] run_acq;     // run length after a move in S_ACQ
    logic             at_wrap;     // count_in sits at the wrap point of step

    assign is_move    = (step == STEP_UP) || (step == STEP_DN);
    assign step_up    = (step == STEP_UP);
    assign same_dir   = (step_up == dir_up);
    assign is_hold_ok = HOLD_OK && (step == STEP_HOLD);
    assign run_inc    = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    assign run_acq    = same_dir ? run_inc : RUN_W'(1);
    assign at_wrap    = step_up ? (count_in == '0)
                                : (count_in == {WIDTH{1'b1}});

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        locked_d  = locked;
        dir_up_d  = dir_up;
        wrap_d    = 1'b0;
        dir_chg_d = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt;

        if (count_vld) begin
            prev_d = count_in;

            case (state_q)
                S_IDLE: begin
                    // First sample only establishes a reference value.
                    state_d = S_ACQ;
                    run_d   = '0;
                end

                S_ACQ: begin
                    if (is_move) begin
                        // An opposite move restarts the run in the new
                        // direction rather than clearing it, since that step
                        // itself is already one legal step.
                        run_d    = run_acq;
                        dir_up_d = step_up;
                        if (run_acq >= RUN_LOCK) begin
                            state_d  = S_LOCK;
                            locked_d = 1'b1;
                        end
                    end else if (!is_hold_ok) begin
                        run_d = '0;
                    end
                end

                S_LOCK: begin
                    if (is_move && same_dir) begin
                        wrap_d = at_wrap;
                    end else if (is_move) begin
                        dir_chg_d = 1'b1;
                        dir_up_d  = step_up;
                        run_d     = RUN_W'(1);
                        // With LOCK_CNT = 1 the reversing step alone already
                        // satisfies the lock criterion in the new direction.
                        if (LOCK_CNT == 1) begin
                            state_d  = S_LOCK;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = S_ACQ;
                            locked_d = 1'b0;
                        end
                    end else if (!is_hold_ok) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = S_ACQ;
                        if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt + ERR_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    run_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            run_q   <= '0;
            locked  <= 1'b0;
            dir_up  <= 1'b0;
            wrap    <= 1'b0;
            dir_chg <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            locked  <= locked_d;
            dir_up  <= dir_up_d;
            wrap    <= wrap_d;
            dir_chg <= dir_chg_d;
            err     <= err_d;
            err_cnt <= err_cnt_d;
        end
    end

    assign dbg_state = state_q;

endmodule : count_seq_monitor

// File: tb/tb_count_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_seq_monitor
//
// Self-checking bench for count_seq_monitor. Two instances share the same
// stimulus: one with default parameters and one with a 2-bit error counter to
// observe saturation. A directed vector table covers the main scenarios, a
// hand-written sequence forces four errors, and a randomized phase is checked
// against a behavioural model of the monitor.
// -----------------------------------------------------------------------------
module tb_count_seq_monitor;
    import seq_mon_pkg::*;

    localparam int W  = 4;
    localparam int LC = 2;

`ifdef SEQ_MON_HOLD_OK_EN
    localparam bit HOLD_OK = 1'b1;
`else
    localparam bit HOLD_OK = 1'b0;
`endif

    // ---------------------------------------------------------------- clock
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         reset;
    logic [W-1:0] count_in;
    logic         count_vld;

    logic         locked, dir_up, wrap, dir_chg, err;
    logic [7:0]   err_cnt;
    state_t       dbg_state;

    logic         s_locked, s_dir_up, s_wrap, s_dir_chg, s_err;
    logic [1:0]   s_err_cnt;
    state_t       s_dbg_state;

    count_seq_monitor #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(8)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .count_in  (count_in),
        .count_vld (count_vld),
        .locked    (locked),
        .dir_up    (dir_up),
        .wrap      (wrap),
        .dir_chg   (dir_chg),
        .err       (err),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    count_seq_monitor #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(2)) dut_sat (
        .Clk       (Clk),
        .reset     (reset),
        .count_in  (count_in),
        .count_vld (count_vld),
        .locked    (s_locked),
        .dir_up    (s_dir_up),
        .wrap      (s_wrap),
        .dir_chg   (s_dir_chg),
        .err       (s_err),
        .err_cnt   (s_err_cnt),
        .dbg_state (s_dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Behavioural view: remember the last value, the direction as +1/-1,
    // how many agreeing steps were seen, and the raw number of errors.
    bit m_have_prev;
    int m_prev;
    bit m_locked;
    int m_dir;
    int m_run;
    int m_errs;
    bit m_wrap, m_chg, m_err;

    task automatic model_step(input logic rst, input logic vld, input logic [W-1:0] val);
        int cur, d, mv;
        m_wrap = 0; m_chg = 0; m_err = 0;
        if (rst) begin
            m_have_prev = 0; m_prev = 0; m_locked = 0; m_dir = -1;
            m_run = 0; m_errs = 0;
        end else if (vld) begin
            cur = int'(val);
            d   = (cur - m_prev + 16) % 16;
            mv  = (d == 1) ? 1 : (d == 15) ? -1 : (d == 0) ? 0 : 99;
            if (!m_have_prev) begin
                m_have_prev = 1;
                m_run = 0;
            end else if (mv == 0 && HOLD_OK) begin
                // repeated value accepted silently
            end else if (mv == 1 || mv == -1) begin
                if (m_locked) begin
                    if (mv == m_dir) begin
                        m_wrap = (mv == 1 && cur == 0) || (mv == -1 && cur == 15);
                    end else begin
                        m_chg = 1; m_dir = mv; m_run = 1;
                        m_locked = (LC == 1);
                    end
                end else begin
                    if (mv == m_dir) m_run++;
                    else begin m_dir = mv; m_run = 1; end
                    if (m_run >= LC) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    m_err = 1; m_errs++; m_locked = 0;
                end
                m_run = 0;
            end
            m_prev = cur;
        end
    endtask

    function automatic logic [31:0] m_state();
        if (!m_have_prev) return 32'(S_IDLE);
        if (m_locked)     return 32'(S_LOCK);
        return 32'(S_ACQ);
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic apply(input logic rst, input logic vld, input logic [W-1:0] val);
        @(negedge Clk);
        reset     = rst;
        count_vld = vld;
        count_in  = val;
        @(posedge Clk);
        #1;
        model_step(rst, vld, val);
        chk("state", 32'(dbg_state), m_state());
        chk("sat_err_cnt", 32'(s_err_cnt), 32'((m_errs > 3) ? 3 : m_errs));
    endtask

    task automatic check_outs(input string tag, input logic l, input logic d,
                              input logic w, input logic c, input logic e,
                              input logic [7:0] ec);
        chk({tag, "_locked"},  32'(locked),  32'(l));
        chk({tag, "_dir_up"},  32'(dir_up),  32'(d));
        chk({tag, "_wrap"},    32'(wrap),    32'(w));
        chk({tag, "_dir_chg"}, 32'(dir_chg), 32'(c));
        chk({tag, "_err"},     32'(err),     32'(e));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ec));
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, m_locked, (m_dir == 1), m_wrap, m_chg, m_err,
                   8'((m_errs > 255) ? 255 : m_errs));
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] val;
        logic         locked;
        logic         dir_up;
        logic         wrap;
        logic         dir_chg;
        logic         err;
        logic [7:0]   err_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [W-1:0] val,
                       input logic l, input logic d, input logic w,
                       input logic c, input logic e, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.vld = vld; v.val = val;
        v.locked = l; v.dir_up = d; v.wrap = w; v.dir_chg = c; v.err = e;
        v.err_cnt = ec;
        vecs.push_back(v);
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        reset = 1'b1; count_vld = 1'b0; count_in = '0;
        model_step(1'b1, 1'b0, '0);

        // reset state
        add(1, 0, 0,   0, 0, 0, 0, 0, 0);
        // lock up: 0,1,2
        add(0, 1, 0,   0, 0, 0, 0, 0, 0);
        add(0, 1, 1,   0, 1, 0, 0, 0, 0);
        add(0, 1, 2,   1, 1, 0, 0, 0, 0);
        for (int v = 3; v <= 15; v++) add(0, 1, W'(v), 1, 1, 0, 0, 0, 0);
        // up wrap 15 -> 0
        add(0, 1, 0,   1, 1, 1, 0, 0, 0);
        add(0, 1, 1,   1, 1, 0, 0, 0, 0);
        for (int v = 2; v <= 5; v++) add(0, 1, W'(v), 1, 1, 0, 0, 0, 0);
        // reversal at 5 -> 4, relock on 3
        add(0, 1, 4,   0, 0, 0, 1, 0, 0);
        add(0, 1, 3,   1, 0, 0, 0, 0, 0);
        add(0, 1, 2,   1, 0, 0, 0, 0, 0);
        add(0, 1, 1,   1, 0, 0, 0, 0, 0);
        add(0, 1, 0,   1, 0, 0, 0, 0, 0);
        // down wrap 0 -> 15
        add(0, 1, 15,  1, 0, 1, 0, 0, 0);
        add(0, 1, 14,  1, 0, 0, 0, 0, 0);
        // reverse to up; the 15 -> 0 step in acquisition is not a wrap pulse
        add(0, 1, 15,  0, 1, 0, 1, 0, 0);
        add(0, 1, 0,   1, 1, 0, 0, 0, 0);
        for (int v = 1; v <= 7; v++) add(0, 1, W'(v), 1, 1, 0, 0, 0, 0);
        // jump 7 -> 9, then relock on 10, 11
        add(0, 1, 9,   0, 1, 0, 0, 1, 1);
        add(0, 1, 10,  0, 1, 0, 0, 0, 1);
        add(0, 1, 11,  1, 1, 0, 0, 0, 1);
        // valid gap of three cycles with garbage on the bus
        add(0, 0, 5,   1, 1, 0, 0, 0, 1);
        add(0, 0, 0,   1, 1, 0, 0, 0, 1);
        add(0, 0, 9,   1, 1, 0, 0, 0, 1);
        add(0, 1, 12,  1, 1, 0, 0, 0, 1);
        // repeated value while locked
`ifdef SEQ_MON_HOLD_OK_EN
        add(0, 1, 12,  1, 1, 0, 0, 0, 1);
        add(0, 1, 13,  1, 1, 0, 0, 0, 1);
        add(0, 1, 14,  1, 1, 0, 0, 0, 1);
`else
        add(0, 1, 12,  0, 1, 0, 0, 1, 2);
        add(0, 1, 13,  0, 1, 0, 0, 0, 2);
        add(0, 1, 14,  1, 1, 0, 0, 0, 2);
`endif
        // reset while locked, then first sample gives no error
        add(1, 1, 3,   0, 0, 0, 0, 0, 0);
        add(0, 1, 9,   0, 0, 0, 0, 0, 0);
        add(0, 1, 10,  0, 1, 0, 0, 0, 0);
        add(0, 1, 11,  1, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].vld, vecs[i].val);
            check_outs($sformatf("vec%0d", i), vecs[i].locked, vecs[i].dir_up,
                       vecs[i].wrap, vecs[i].dir_chg, vecs[i].err,
                       vecs[i].err_cnt);
        end

        // four errors: default counter reads 4, 2-bit counter saturates at 3
        begin
            logic [W-1:0] seq[$];
            seq = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2,
                    4'd9, 4'd10, 4'd11, 4'd4};
            apply(1'b1, 1'b0, '0);
            check_model("sat_rst");
            foreach (seq[i]) begin
                apply(1'b0, 1'b1, seq[i]);
                check_model($sformatf("sat%0d", i));
            end
            chk("err_cnt_four", 32'(err_cnt), 32'd4);
            chk("err_cnt_saturated", 32'(s_err_cnt), 32'd3);
        end

        // randomized stream against the model
        begin
            int dirv;
            logic [W-1:0] nv;
            logic rst_r, vld_r;
            dirv = 1;
            for (int n = 0; n < 800; n++) begin
                rst_r = ($urandom_range(0, 199) == 0);
                vld_r = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 15) == 0) dirv = -dirv;
                case ($urandom_range(0, 9))
                    0:       nv = W'($urandom_range(0, 15));
                    1:       nv = W'(m_prev);
                    default: nv = W'(m_prev + dirv);
                endcase
                apply(rst_r, vld_r, nv);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_count_seq_monitor
